pad_key_decoder: RTL

// - Converts the PS/2 scan-code byte stream from the keyboard receiver into held-key levels.
// - Outputs up/down for both pads and a start pulse for the game FSM.
// - Sits between the PS/2 byte receiver and the two player pad controllers.
// - Decodes make, break (F0) and extended (E0) sequences and masks conflicting up+down presses.

---
 rtl/pad_key_decoder_if.sv | 25 ++
 rtl/pad_key_decoder.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/pad_key_decoder_if.sv
// Byte stream from the PS/2 receiver into the key decoder, plus the decoded pad levels and pulses.
// The master is the receiver/game side; the slave is pad_key_decoder.
interface pad_key_decoder_if;
    // rx_valid is a single-cycle strobe with no back-pressure: rx_data is consumed
    // on every clk edge where rx_valid=1, and the decoder never stalls the sender.
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       up_p1;
    logic       down_p1;
    logic       up_p2;
    logic       down_p2;
    logic       start_pulse;
    logic       seq_err;
    logic [1:0] dbg_state;

    modport master (
        output rx_data, rx_valid,
        input  up_p1, down_p1, up_p2, down_p2, start_pulse, seq_err, dbg_state
    );

    modport slave (
        input  rx_data, rx_valid,
        output up_p1, down_p1, up_p2, down_p2, start_pulse, seq_err, dbg_state
    );
endinterface

// File: rtl/pad_key_decoder.sv
// PS/2 scan-code decoder: make/break/extended sequences into held pad levels, start pulse and error pulse.
// Define PAD_KEY_TIMEOUT_EN to abandon an unfinished sequence after TIMEOUT_CYCLES idle cycles.
module pad_key_decoder #(
    parameter logic [7:0] KEY_P1_UP      = 8'h1D,
    parameter logic [7:0] KEY_P1_DOWN    = 8'h1B,
    parameter logic [7:0] KEY_P2_UP      = 8'h75,
    parameter logic [7:0] KEY_P2_DOWN    = 8'h72,
    parameter logic [7:0] KEY_START      = 8'h29,
    parameter int         TIMEOUT_CYCLES = 200_000
) (
    input  logic clk,
    input  logic rst,
    pad_key_decoder_if.slave bus
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_BRK     = 2'd1;
    localparam logic [1:0] ST_EXT     = 2'd2;
    localparam logic [1:0] ST_EXT_BRK = 2'd3;

    localparam logic [7:0] CODE_EXT = 8'hE0;
    localparam logic [7:0] CODE_BRK = 8'hF0;

    logic [1:0] state_q, state_d;
    logic       h_u1_q, h_u1_d;
    logic       h_d1_q, h_d1_d;
    logic       h_u2_q, h_u2_d;
    logic       h_d2_q, h_d2_d;
    logic       h_st_q, h_st_d;
    logic       start_q, start_d;
    logic       err_q, err_d;

    logic       is_prefix;
    logic       evt_valid;
    logic       evt_make;
    logic       evt_ext;
    logic       timeout_hit;

    assign is_prefix = (bus.rx_data == CODE_EXT) || (bus.rx_data == CODE_BRK);

`ifdef PAD_KEY_TIMEOUT_EN
    localparam int              CNT_W  = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Any received byte restarts the wait; IDLE has nothing to abandon.
    assign timeout_hit = (state_q != ST_IDLE) && !bus.rx_valid && (cnt_q == CNT_MAX);

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (bus.rx_valid || (state_q == ST_IDLE) || timeout_hit) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    // Sequence FSM: classifies each byte as a prefix, a key event, or a protocol error.
    always_comb begin
        state_d   = state_q;
        err_d     = 1'b0;
        evt_valid = 1'b0;
        evt_make  = 1'b0;
        evt_ext   = 1'b0;
        if (bus.rx_valid) begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.rx_data == CODE_EXT) begin
                        state_d = ST_EXT;
                    end else if (bus.rx_data == CODE_BRK) begin
                        state_d = ST_BRK;
                    end else begin
                        evt_valid = 1'b1;
                        evt_make  = 1'b1;
                    end
                end
                ST_BRK: begin
                    state_d = ST_IDLE;
                    if (is_prefix) begin
                        err_d = 1'b1;
                    end else begin
                        evt_valid = 1'b1;
                    end
                end
                ST_EXT: begin
                    if (bus.rx_data == CODE_BRK) begin
                        state_d = ST_EXT_BRK;
                    end else if (bus.rx_data == CODE_EXT) begin
                        state_d = ST_IDLE;
                        err_d   = 1'b1;
                    end else begin
                        state_d   = ST_IDLE;
                        evt_valid = 1'b1;
                        evt_make  = 1'b1;
                        evt_ext   = 1'b1;
                    end
                end
                ST_EXT_BRK: begin
                    state_d = ST_IDLE;
                    if (is_prefix) begin
                        err_d = 1'b1;
                    end else begin
                        evt_valid = 1'b1;
                        evt_ext   = 1'b1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end else if (timeout_hit) begin
            state_d = ST_IDLE;
            err_d   = 1'b1;
        end
    end

    // Key flags: a code only matches within its own class, so keypad 8 (plain 75) never moves P2.
    always_comb begin
        h_u1_d  = h_u1_q;
        h_d1_d  = h_d1_q;
        h_u2_d  = h_u2_q;
        h_d2_d  = h_d2_q;
        h_st_d  = h_st_q;
        start_d = 1'b0;
        if (evt_valid) begin
            if (!evt_ext) begin
                if (bus.rx_data == KEY_P1_UP) begin
                    h_u1_d = evt_make;
                end
                if (bus.rx_data == KEY_P1_DOWN) begin
                    h_d1_d = evt_make;
                end
                if (bus.rx_data == KEY_START) begin
                    h_st_d  = evt_make;
                    start_d = evt_make && !h_st_q;
                end
            end else begin
                if (bus.rx_data == KEY_P2_UP) begin
                    h_u2_d = evt_make;
                end
                if (bus.rx_data == KEY_P2_DOWN) begin
                    h_d2_d = evt_make;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            h_u1_q  <= 1'b0;
            h_d1_q  <= 1'b0;
            h_u2_q  <= 1'b0;
            h_d2_q  <= 1'b0;
            h_st_q  <= 1'b0;
            start_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            h_u1_q  <= h_u1_d;
            h_d1_q  <= h_d1_d;
            h_u2_q  <= h_u2_d;
            h_d2_q  <= h_d2_d;
            h_st_q  <= h_st_d;
            start_q <= start_d;
            err_q   <= err_d;
        end
    end

    // Holding both directions of one pad cancels out so the paddle stays put.
    assign bus.up_p1       = h_u1_q & ~h_d1_q;
    assign bus.down_p1     = h_d1_q & ~h_u1_q;
    assign bus.up_p2       = h_u2_q & ~h_d2_q;
    assign bus.down_p2     = h_d2_q & ~h_u2_q;
    assign bus.start_pulse = start_q;
    assign bus.seq_err     = err_q;
    assign bus.dbg_state   = state_q;

endmodule
